mole_autoplayer: RTL and testbench

Self-playing opponent for the whack-a-mole core: watches the game's 7-segment outputs, decodes which segment (mole) is lit, waits a configurable reaction time, then drives the matching button long enough to pass the button debouncers. It is the responder side of the display→button loop and is used for on-chip demo mode and closed-loop self-test. It also has a deliberate-miss mode to exercise the game's wrong-button lockout path.

---
 rtl/mole_pkg.sv | 37 +++
 rtl/mole_autoplayer_if.sv | 31 +++
 rtl/mole_seg_decode.sv | 29 ++
 rtl/mole_autoplayer.sv | 184 ++++++++++++++++++
 tb/tb_mole_autoplayer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole autoplayer and display-side helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mole_pkg;

  // Autoplayer FSM encoding.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WATCH   = 3'd1,
    REACT   = 3'd2,
    PRESS   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Number of mole positions, one per 7-segment segment.
  localparam int NUM_SEGS = 7;

  // Default timing parameters for the autoplayer.
  localparam int DEF_SETTLE_CYCLES  = 2;
  localparam int DEF_HOLD_CYCLES    = 8;
  localparam int DEF_RELEASE_CYCLES = 8;

  // One-hot button drive for a mole index. Bit 7 has no mole behind it
  // and is masked off so it can never be driven.
  function automatic logic [7:0] onehot_btn(input logic [2:0] idx);
    logic [7:0] r;
    r = 8'h01 << idx;
    return r & 8'h7F;
  endfunction

  // Deliberately wrong neighbour of a mole index, wrapping 6 -> 0.
  function automatic logic [2:0] miss_idx(input logic [2:0] idx);
    return (idx == 3'd6) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/mole_autoplayer_if.sv
// Bundle between the whack-a-mole game and its autoplayer.
// Latency: n/a (wires only).
// Backpressure: none; the autoplayer is open-loop on the display and buttons.
// Ports: enable, seg_in, dp_in, reaction_cfg, inject_miss (game/control side -> autoplayer);
//        btn_out, press_count, busy, done (autoplayer -> game/control side).
interface mole_autoplayer_if;
  import mole_pkg::*;

  logic                enable;
  logic [NUM_SEGS-1:0] seg_in;
  logic                dp_in;
  logic [7:0]          reaction_cfg;
  logic                inject_miss;
  logic [7:0]          btn_out;
  logic [7:0]          press_count;
  logic                busy;
  logic                done;

  // Game/control side: drives the display and configuration, watches the buttons.
  modport master (
    output enable, seg_in, dp_in, reaction_cfg, inject_miss,
    input  btn_out, press_count, busy, done
  );

  // Autoplayer side.
  modport slave (
    input  enable, seg_in, dp_in, reaction_cfg, inject_miss,
    output btn_out, press_count, busy, done
  );

endinterface

// File: rtl/mole_seg_decode.sv
// Decodes an active-low 7-segment pattern into a single lit-segment index.
// Latency: combinational.
// Backpressure: none. Ports: seg (active-low segments) in; valid, idx (0..6) out.
module mole_seg_decode
  import mole_pkg::*;
(
  input  logic [NUM_SEGS-1:0] seg,
  output logic                valid,
  output logic [2:0]          idx
);

  logic [2:0] zeros;

  // Exactly one low segment is a mole; no lows or several lows are not.
  // idx is only meaningful when valid is high.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    zeros = 3'd0;
    for (int i = 0; i < NUM_SEGS; i++) begin
      if (!seg[i]) begin
        zeros = zeros + 3'd1;
        idx   = 3'(i);
      end
    end
    valid = (zeros == 3'd1);
  end

endmodule

// File: rtl/mole_autoplayer.sv
// Self-playing responder: decodes the lit mole, waits the reaction time, presses its button.
// Latency: 1 sample + SETTLE_CYCLES + reaction_cfg cycles from seg_in change to button high.
// Backpressure: none; outputs are registered, pulses are fixed-width and fixed-spacing.
// Ports: clk, rst_n (async active-low); bus (slave): enable, seg_in, dp_in, reaction_cfg,
//        inject_miss in; btn_out, press_count, busy, done out.
module mole_autoplayer
  import mole_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  mole_autoplayer_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] S_ONE      = SW'(1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] H_ONE      = HW'(1);
  localparam logic [RW-1:0] REL_MAX    = RW'(RELEASE_CYCLES);
  localparam logic [RW-1:0] R_ONE      = RW'(1);

  // Registered copies of the game outputs; every decision uses these.
  logic [NUM_SEGS-1:0] s_seg;
  logic                s_dp;

  state_t        state_q, state_n;
  logic [SW-1:0] settle_q, settle_n, settle_adv;
  logic [7:0]    delay_q, delay_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [RW-1:0] rel_q, rel_n;
  logic [2:0]    tgt_q, tgt_n;
  logic [2:0]    prev_q, prev_n;
  logic [7:0]    btn_q, btn_n;
  logic [7:0]    count_q, count_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  logic          dec_valid;
  logic [2:0]    dec_idx;

  mole_seg_decode u_decode (
    .seg   (s_seg),
    .valid (dec_valid),
    .idx   (dec_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg    <= 7'h7F;
      s_dp     <= 1'b0;
      state_q  <= IDLE;
      settle_q <= '0;
      delay_q  <= 8'd0;
      hold_q   <= '0;
      rel_q    <= '0;
      tgt_q    <= 3'd0;
      prev_q   <= 3'd0;
      btn_q    <= 8'h00;
      count_q  <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      s_seg    <= bus.seg_in;
      s_dp     <= bus.dp_in;
      state_q  <= state_n;
      settle_q <= settle_n;
      delay_q  <= delay_n;
      hold_q   <= hold_n;
      rel_q    <= rel_n;
      tgt_q    <= tgt_n;
      prev_q   <= prev_n;
      btn_q    <= btn_n;
      count_q  <= count_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    settle_n   = settle_q;
    delay_n    = delay_q;
    hold_n     = hold_q;
    rel_n      = rel_q;
    tgt_n      = tgt_q;
    count_n    = count_q;
    settle_adv = '0;
    prev_n     = dec_valid ? dec_idx : prev_q;

    // Stability run length of the current mole. A zero count means the
    // previous cycle had no valid mole, so any valid index starts a new run.
    if (!dec_valid) begin
      settle_adv = '0;
    end else if (settle_q == '0 || dec_idx != prev_q) begin
      settle_adv = S_ONE;
    end else begin
      settle_adv = settle_q + S_ONE;
    end

    case (state_q)
      IDLE: begin
        if (bus.enable && s_dp) begin
          state_n = WATCH;
        end
      end
      WATCH: begin
        settle_n = settle_adv;
        // Decide on the same edge the run reaches its length, so the press
        // (or the reaction countdown) starts without an extra cycle.
        if (settle_adv == SETTLE_MAX) begin
          tgt_n   = bus.inject_miss ? miss_idx(dec_idx) : dec_idx;
          delay_n = bus.reaction_cfg;
          hold_n  = H_ONE;
          state_n = (bus.reaction_cfg == 8'd0) ? PRESS : REACT;
        end
      end
      REACT: begin
        if (delay_q <= 8'd1) begin
          state_n = PRESS;
          hold_n  = H_ONE;
        end else begin
          delay_n = delay_q - 8'd1;
        end
      end
      PRESS: begin
        if (hold_q == HOLD_MAX) begin
          state_n = RELEASE;
          rel_n   = R_ONE;
        end else begin
          hold_n = hold_q + H_ONE;
        end
      end
      RELEASE: begin
        if (rel_q == REL_MAX) begin
          state_n = WATCH;
        end else begin
          rel_n = rel_q + R_ONE;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Game over wins over an enable drop; DONE only leaves through reset.
    if (state_q != IDLE && state_q != DONE && !s_dp) begin
      state_n = DONE;
    end else if (state_q != DONE && !bus.enable) begin
      state_n = IDLE;
    end

    // Leaving WATCH for any reason forgets the run, so a mole that stays
    // lit through a press must re-settle before it is pressed again.
    if (state_n != WATCH) begin
      settle_n = '0;
    end

    // Count on the entry edge only, after the overrides above have had
    // their say, so an abandoned entry is never counted.
    if (state_n == PRESS && state_q != PRESS && count_q != 8'hFF) begin
      count_n = count_q + 8'd1;
    end

    btn_n  = (state_n == PRESS) ? onehot_btn(tgt_n) : 8'h00;
    busy_n = (state_n == REACT) || (state_n == PRESS) || (state_n == RELEASE);
    done_n = (state_n == DONE);
  end

  assign bus.btn_out     = btn_q;
  assign bus.press_count = count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_mole_autoplayer.sv
// Directed bench for mole_autoplayer: expected button pulses are queued as stimulus is driven
// and checked (value, start cycle, width) by a monitor when the DUT raises btn_out.
// Status outputs are checked at fixed points of the directed sequence.
module tb_mole_autoplayer;
  import mole_pkg::*;

  localparam int SETTLE = 2;
  localparam int HOLD   = 8;
  localparam int REL    = 8;
  localparam int PER    = HOLD + REL + SETTLE;

  typedef struct {
    logic [7:0] btn;
    int         cyc;
    bit         full;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  mole_autoplayer_if bus();

  mole_autoplayer #(
    .SETTLE_CYCLES  (SETTLE),
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [7:0] b, input int c, input bit full);
    exp_t e;
    e.btn  = b;
    e.cyc  = c;
    e.full = full;
    q.push_back(e);
  endtask

  // Pulse monitor: each rising btn_out must match the head of the queue.
  initial begin : monitor
    logic [7:0] prev_btn;
    int         hi_cnt;
    bit         cur_full;
    exp_t       e;
    prev_btn = 8'h00;
    hi_cnt   = 0;
    cur_full = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.btn_out !== 8'h00 && prev_btn === 8'h00) begin
        check("pulse_expected", 32'(q.size() != 0), 32'd1);
        cur_full = 1'b0;
        if (q.size() != 0) begin
          e = q.pop_front();
          check("pulse_btn", bus.btn_out, e.btn);
          check("pulse_cycle", cyc, e.cyc);
          cur_full = e.full;
        end
        check("pulse_onehot", 32'($onehot(bus.btn_out)), 32'd1);
        hi_cnt = 1;
      end else if (bus.btn_out !== 8'h00) begin
        hi_cnt++;
      end else if (prev_btn !== 8'h00 && cur_full) begin
        check("pulse_width", hi_cnt, HOLD);
      end
      prev_btn = bus.btn_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    bus.enable       = 1'b0;
    bus.seg_in       = 7'h7F;
    bus.dp_in        = 1'b0;
    bus.reaction_cfg = 8'd0;
    bus.inject_miss  = 1'b0;
    rst_n            = 1'b1;
    #1 rst_n = 1'b0;
    tick(3);
    check("rst_btn", bus.btn_out, 8'h00);
    check("rst_count", bus.press_count, 8'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);

    rst_n = 1'b1;
    bus.enable = 1'b1;
    bus.dp_in  = 1'b1;
    tick(3);
    check("watch_busy", bus.busy, 1'b0);
    check("watch_done", bus.done, 1'b0);

    // Mole 3, no reaction delay: press 1+SETTLE edges after the change.
    c = cyc;
    bus.seg_in = 7'b1110111;
    expect_pulse(8'h08, c + 1 + SETTLE, 1'b1);
    tick(12);
    bus.seg_in = 7'h7F;
    check("t1_release_busy", bus.busy, 1'b1);
    check("t1_release_btn", bus.btn_out, 8'h00);
    check("t1_count", bus.press_count, 8'd1);
    tick(10);
    check("t1_watch_busy", bus.busy, 1'b0);
    check("t1_count_after", bus.press_count, 8'd1);

    // Mole 5 with R=10; a display change during REACT is ignored.
    bus.reaction_cfg = 8'd10;
    c = cyc;
    bus.seg_in = 7'b1011111;
    expect_pulse(8'h20, c + 1 + SETTLE + 10, 1'b1);
    tick(5);
    check("t2_react_busy", bus.busy, 1'b1);
    check("t2_react_btn", bus.btn_out, 8'h00);
    bus.seg_in = 7'b1111101;
    tick(17);
    bus.seg_in = 7'h7F;
    tick(10);
    check("t2_count", bus.press_count, 8'd2);
    bus.reaction_cfg = 8'd0;

    // Deliberate misses: 6 wraps to 0, 2 goes to 3.
    bus.inject_miss = 1'b1;
    c = cyc;
    bus.seg_in = 7'b0111111;
    expect_pulse(8'h01, c + 1 + SETTLE, 1'b1);
    tick(12);
    bus.seg_in = 7'h7F;
    tick(10);
    c = cyc;
    bus.seg_in = 7'b1111011;
    expect_pulse(8'h08, c + 1 + SETTLE, 1'b1);
    tick(12);
    bus.seg_in = 7'h7F;
    tick(10);
    bus.inject_miss = 1'b0;
    check("t3_count", bus.press_count, 8'd4);

    // Invalid displays never trigger a press.
    bus.seg_in = 7'b1110110;
    tick(50);
    check("t4_two_btn", bus.btn_out, 8'h00);
    check("t4_two_busy", bus.busy, 1'b0);
    check("t4_two_count", bus.press_count, 8'd4);
    bus.seg_in = 7'h7F;
    tick(50);
    check("t4_none_btn", bus.btn_out, 8'h00);
    check("t4_none_done", bus.done, 1'b0);
    check("t4_none_count", bus.press_count, 8'd4);

    // Game over in the middle of a press.
    c = cyc;
    bus.seg_in = 7'b1110111;
    expect_pulse(8'h08, c + 1 + SETTLE, 1'b0);
    tick(5);
    bus.dp_in = 1'b0;
    tick(1);
    check("t5_sample_btn", bus.btn_out, 8'h08);
    check("t5_sample_done", bus.done, 1'b0);
    tick(1);
    check("t5_done_btn", bus.btn_out, 8'h00);
    check("t5_done", bus.done, 1'b1);
    check("t5_done_busy", bus.busy, 1'b0);
    check("t5_count", bus.press_count, 8'd5);
    bus.dp_in = 1'b1;
    tick(20);
    check("t5_sticky_done", bus.done, 1'b1);
    check("t5_sticky_btn", bus.btn_out, 8'h00);
    rst_n = 1'b0;
    tick(1);
    check("t5_rst_done", bus.done, 1'b0);
    check("t5_rst_count", bus.press_count, 8'd0);
    bus.seg_in = 7'h7F;
    rst_n = 1'b1;
    tick(3);

    // 300 back-to-back hits saturate the counter; the 301st press is abandoned.
    c = cyc;
    bus.seg_in = 7'b1110111;
    for (int k = 0; k <= 300; k++) begin
      expect_pulse(8'h08, c + 1 + SETTLE + PER * k, k < 300);
    end
    tick(1 + SETTLE + PER * 300 + 3);
    check("t6_in_press_btn", bus.btn_out, 8'h08);
    check("t6_saturated", bus.press_count, 8'd255);
    bus.enable = 1'b0;
    tick(1);
    check("t6_drop_btn", bus.btn_out, 8'h00);
    check("t6_drop_busy", bus.busy, 1'b0);
    check("t6_drop_count", bus.press_count, 8'd255);
    bus.seg_in = 7'h7F;
    tick(2);

    // Asynchronous reset while reacting.
    bus.enable = 1'b1;
    tick(3);
    bus.reaction_cfg = 8'd20;
    bus.seg_in = 7'b1011111;
    tick(6);
    check("t7_react_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_count", bus.press_count, 8'd0);
    check("t7_async_busy", bus.busy, 1'b0);
    check("t7_async_btn", bus.btn_out, 8'h00);
    check("t7_async_done", bus.done, 1'b0);
    bus.enable = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(30);
    check("t7_after_btn", bus.btn_out, 8'h00);
    check("t7_after_count", bus.press_count, 8'd0);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
